// File: rtl/spi_master_gen_if.sv
// spi_master_gen_if: register-block side of the SPI master (configuration, data words, handshake)
interface spi_master_gen_if #(
  parameter int DATA_W   = 8,
  parameter int DIV_W    = 5,
  parameter int CS_COUNT = 2
);
  localparam int CS_W = CS_COUNT > 1 ? $clog2(CS_COUNT) : 1;
  logic [DIV_W-1:0]  divider;
  logic              cpol;
  logic              cpha;
  logic              lsb_first;
  logic [CS_W-1:0]   cs_sel;
  logic              keep_cs;
  logic              cs_release;
  logic [DATA_W-1:0] data_tx;
  logic              txn_start;
  logic [DATA_W-1:0] data_rx;
  logic              txn_done;
  logic              busy;
  modport master (
    output divider, cpol, cpha, lsb_first, cs_sel, keep_cs, cs_release, data_tx, txn_start,
    input  data_rx, txn_done, busy
  );
  modport slave (
    input  divider, cpol, cpha, lsb_first, cs_sel, keep_cs, cs_release, data_tx, txn_start,
    output data_rx, txn_done, busy
  );
endinterface

// File: rtl/spi_master_gen.sv
// spi_master_gen: one-word SPI master with CPOL/CPHA modes, bit order and multi-slave chip select
module spi_master_gen #(
  parameter int DATA_W   = 8,
  parameter int DIV_W    = 5,
  parameter int CS_COUNT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  spi_master_gen_if.slave     bus,
  output logic                spi_clk,
  output logic                spi_mosi,
  input  logic                spi_miso,
  output logic [CS_COUNT-1:0] spi_cs_n
);
  localparam int EW = $clog2(2 * DATA_W);
  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
  state_t state, state_nx;
  logic [DIV_W-1:0]  cnt, div_r;
  logic [EW-1:0]     edge_cnt;
  logic              cpha_r, lsb_r, keep_r;
  logic [DATA_W-1:0] tx_sh, rx_sh;
  logic              ev, lead, last, sample, done_nx;
  function automatic logic head_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction
  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v >> 1 : v << 1;
  endfunction
  assign ev       = cnt == div_r;
  assign lead     = !edge_cnt[0];
  assign last     = edge_cnt == EW'(2 * DATA_W - 1);
  assign sample   = lead ^ cpha_r;
  assign bus.busy = state != IDLE;
  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    if (state == IDLE) state_nx = bus.txn_start ? SETUP : IDLE;
    else if (ev) begin
      state_nx = state == SETUP ? XFER : state == XFER ? (last ? HOLD : XFER) : IDLE;
      done_nx  = state == HOLD;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      div_r        <= '0;
      edge_cnt     <= '0;
      cpha_r       <= 1'b0;
      lsb_r        <= 1'b0;
      keep_r       <= 1'b0;
      tx_sh        <= '0;
      rx_sh        <= '0;
      spi_clk      <= 1'b0;
      spi_mosi     <= 1'b0;
      spi_cs_n     <= '1;
      bus.data_rx  <= '0;
      bus.txn_done <= 1'b0;
    end else begin
      bus.txn_done <= done_nx;
      cnt          <= (state == IDLE || ev) ? '0 : cnt + 1'b1;
      if (state == IDLE) begin
        spi_clk  <= bus.cpol;
        edge_cnt <= '0;
        if (bus.txn_start) begin
          div_r    <= bus.divider;
          cpha_r   <= bus.cpha;
          lsb_r    <= bus.lsb_first;
          keep_r   <= bus.keep_cs;
          spi_cs_n <= ~(CS_COUNT'(1) << bus.cs_sel);
          tx_sh    <= bus.cpha ? bus.data_tx : advance(bus.data_tx, bus.lsb_first);
          if (!bus.cpha) spi_mosi <= head_bit(bus.data_tx, bus.lsb_first);
        end else if (bus.cs_release) spi_cs_n <= '1;
      end else if (ev && state == XFER) begin
        spi_clk  <= !spi_clk;
        edge_cnt <= edge_cnt + 1'b1;
        if (sample) rx_sh <= lsb_r ? {spi_miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], spi_miso};
        else if (!last) begin
          spi_mosi <= head_bit(tx_sh, lsb_r);
          tx_sh    <= advance(tx_sh, lsb_r);
        end
      end else if (ev && state == HOLD) begin
        bus.data_rx <= rx_sh;
        if (!keep_r) spi_cs_n <= '1;
      end
    end
  end
endmodule

// File: tb/tb_spi_master_gen.sv
// tb_spi_master_gen: directed and randomized transactions against a wire-level slave model
module tb_spi_master_gen;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_clk, spi_mosi, spi_miso;
  logic [1:0] spi_cs_n;
  int         n_chk = 0, n_err = 0;
  int         sk_n = 0, s_ptr = 0;
  logic [7:0] s_tx = '0, s_rx = '0;
  logic       miso_s = 1'b0, m_cpha = 1'b0, loop_en = 1'b1;
  spi_master_gen_if #(.DATA_W(8), .DIV_W(5), .CS_COUNT(2)) bus ();
  spi_master_gen #(.DATA_W(8), .DIV_W(5), .CS_COUNT(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
  );
  always #5 clk = ~clk;
  assign spi_miso = loop_en ? spi_mosi : miso_s;
  // Slave: even edge count = leading edge; samples MOSI or shifts out its word (wire order MSB first)
  always @(spi_clk) if (bus.busy) begin
    if (((sk_n % 2) == 0) ^ m_cpha) s_rx = {s_rx[6:0], spi_mosi};
    else if (s_ptr < 8) begin
      miso_s = s_tx[7 - s_ptr];
      s_ptr++;
    end
    sk_n++;
  end
  function automatic logic [7:0] rev8(input logic [7:0] v);
    for (int i = 0; i < 8; i++) rev8[i] = v[7 - i];
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_cfg(input logic [7:0] tx, input logic [7:0] stx, input int dv,
                         input logic pol, input logic pha, input logic lsb, input logic lp,
                         input logic csel, input logic kcs);
    bus.data_tx = tx; bus.divider = 5'(dv); bus.cpol = pol; bus.cpha = pha;
    bus.lsb_first = lsb; bus.cs_sel = csel; bus.keep_cs = kcs;
    loop_en = lp; m_cpha = pha; s_tx = stx; s_rx = '0; sk_n = 0;
    s_ptr = pha ? 0 : 1;
    miso_s = pha ? 1'b0 : stx[7];
  endtask
  task automatic run_txn(input logic [7:0] tx, input logic [7:0] stx, input int dv,
                         input logic pol, input logic pha, input logic lsb, input logic lp,
                         input logic csel, input logic kcs, input logic rel, input logic poke);
    int lat;
    logic cs_bad;
    logic [1:0] cs_on;
    cs_on = csel ? 2'b01 : 2'b10;
    @(negedge clk);
    set_cfg(tx, stx, dv, pol, pha, lsb, lp, csel, kcs);
    if (spi_clk !== pol) @(negedge clk);
    bus.txn_start = 1'b1; bus.cs_release = rel;
    @(posedge clk); #1;
    bus.txn_start = 1'b0; bus.cs_release = 1'b0;
    chk("busy_at_accept", 32'(bus.busy), 1);
    lat = 0; cs_bad = 1'b0;
    while (!bus.txn_done && lat < 4000) begin
      if (spi_cs_n !== cs_on) cs_bad = 1'b1;
      if (poke && lat == 5) begin bus.txn_start = 1'b1; bus.data_tx = ~tx; end
      if (poke && lat == 6) bus.txn_start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk("done_latency", 32'(lat), 32'(18 * (dv + 1)));
    chk("data_rx", 32'(bus.data_rx), 32'(lp ? tx : (lsb ? rev8(stx) : stx)));
    chk("slave_rx", 32'(s_rx), 32'(lsb ? rev8(tx) : tx));
    chk("sck_edges", 32'(sk_n), 16);
    chk("sck_idle", 32'(spi_clk), 32'(pol));
    chk("cs_during", 32'(cs_bad), 0);
    chk("cs_after", 32'(spi_cs_n), 32'(kcs ? cs_on : 2'b11));
    chk("busy_at_done", 32'(bus.busy), 0);
  endtask
  initial begin
    int n, extra;
    bus.txn_start = 1'b0; bus.cs_release = 1'b0; bus.data_tx = '0; bus.divider = '0;
    bus.cpol = 1'b1; bus.cpha = 1'b0; bus.lsb_first = 1'b0; bus.cs_sel = 1'b0; bus.keep_cs = 1'b0;
    #12;
    chk("rst_sck", 32'(spi_clk), 0);
    chk("rst_mosi", 32'(spi_mosi), 0);
    chk("rst_cs", 32'(spi_cs_n), 32'h3);
    chk("rst_rx", 32'(bus.data_rx), 0);
    chk("rst_done", 32'(bus.txn_done), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("sck_takes_cpol", 32'(spi_clk), 1);
    run_txn(8'hA5, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int m = 0; m < 4; m++)
      run_txn(8'h3C, 8'h00, 3, m[1], m[0], 0, 1, 0, 0, 0, 0);
    run_txn(8'h01, 8'h80, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    run_txn(8'h01, 8'h80, 0, 1, 1, 1, 0, 1, 0, 0, 0);
    run_txn(8'h5A, 8'hC3, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    run_txn(8'h96, 8'h3E, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    run_txn(8'h11, 8'h22, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    run_txn(8'h77, 8'h88, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    run_txn(8'h99, 8'h66, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    @(negedge clk); bus.cs_release = 1'b1;
    @(negedge clk); bus.cs_release = 1'b0;
    chk("cs_release", 32'(spi_cs_n), 32'h3);
    run_txn(8'hE7, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    extra = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (bus.txn_done) extra++;
    end
    chk("no_queued_start", 32'(extra), 0);
    @(negedge clk);
    set_cfg(8'hF0, 8'h0F, 1, 1, 0, 0, 0, 1, 0);
    @(negedge clk); bus.txn_start = 1'b1;
    @(posedge clk); #1; bus.txn_start = 1'b0;
    n = 0;
    while (sk_n < 5 && n < 1000) begin @(posedge clk); #1; n++; end
    chk("reached_5th_edge", 32'(sk_n), 5);
    rst_n = 1'b0; #1;
    chk("abort_sck", 32'(spi_clk), 0);
    chk("abort_mosi", 32'(spi_mosi), 0);
    chk("abort_cs", 32'(spi_cs_n), 32'h3);
    chk("abort_rx", 32'(bus.data_rx), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.txn_done) extra++;
    end
    chk("abort_no_done", 32'(extra), 0);
    @(negedge clk); rst_n = 1'b1;
    run_txn(8'h6B, 8'hD2, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      logic [7:0] tx, stx;
      tx = 8'($urandom); stx = 8'($urandom);
      run_txn(tx, stx, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/spi_master_gen.md
# spi_master_gen

Parametrised SPI master engine, the successor to the fixed 8-bit mode-0 SPI core. It adds configurable word width, all four CPOL/CPHA modes, MSB/LSB-first ordering, and multi-slave chip-select generation with optional CS hold across back-to-back words. It sits between the CPU's memory-mapped SPI register block and the pad ring. It moves one word per `txn_start` and signals completion with a one-cycle `txn_done` pulse.

## Interface
- `DATA_W`, default 8: word width in bits, legal values 2..32.
- `DIV_W`, default 5: width of `divider`.
- `CS_COUNT`, default 2: number of chip-select outputs, legal values 1..8.
- `clk`  in  1: single clock; everything is on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `divider`  in  DIV_W: SCK half-period is `divider`+1 clk cycles.
- `cpol`  in  1: SCK idle level.
- `cpha`  in  1: 0 = sample on leading edge; 1 = sample on trailing edge.
- `lsb_first`  in  1: 1 = shift LSB first.
- `cs_sel`  in  $clog2(CS_COUNT) (min 1): slave index.
- `keep_cs`  in  1: 1 = leave CS asserted after this word.
- `cs_release`  in  1: pulse in IDLE to deassert every CS.
- `data_tx`  in  DATA_W: word to send.
- `txn_start`  in  1: start request, sampled in IDLE only.
- `data_rx`  out  DATA_W: last received word, held until the next `txn_done`.
- `txn_done`  out  1: one-cycle pulse when a word completes.
- `busy`  out  1: high from the accepting edge until `txn_done`.
- `spi_clk`  out  1: SCK.
- `spi_mosi`  out  1: serial data out.
- `spi_miso`  in  1: serial data in.
- `spi_cs_n`  out  CS_COUNT: active-low chip selects.

## Operation
- States:
  - IDLE → SETUP on `txn_start`.
  - SETUP → XFER after one half-period.
  - XFER → HOLD after 2·DATA_W SCK edges.
  - HOLD → IDLE after one half-period, with `txn_done` pulsed on that transition.
- At accept, the block latches `divider`, `cpol`, `cpha`, `lsb_first`, `cs_sel`, `keep_cs` and `data_tx`. Input changes during a transaction have no effect.
- Half-period counter:
  - Counts 0..`divider` in SETUP, XFER and HOLD. Reaching `divider` is an "event", after which the counter returns to 0.
  - The counter is cleared on every state change.
- SCK:
  - In IDLE, `spi_clk` <= `cpol` every cycle.
  - In XFER, each event toggles `spi_clk`. Odd-numbered events are leading edges; even-numbered events are trailing edges.
- Data path:
  - CPHA=0: the first bit is driven on `spi_mosi` on entry to SETUP. MISO is sampled on leading edges; the next bit is driven on trailing edges, except the final one.
  - CPHA=1: a bit is driven on each leading edge; MISO is sampled on each trailing edge.
  - Bit order is MSB first unless `lsb_first`=1. `data_rx` is assembled in a shadow shift register and copied to `data_rx` on entering IDLE.
- Chip select:
  - On SETUP entry, `spi_cs_n[cs_sel]` goes low and all other CS lines go high.
  - On HOLD exit, CS goes high unless `keep_cs`=1, in which case it stays low in IDLE.
  - `cs_release` in IDLE forces all CS lines high. If `txn_start` and `cs_release` are asserted in the same cycle, `txn_start` wins.
- `spi_mosi` holds its last value outside XFER/SETUP.
- `txn_start` while `busy` is ignored, with no queueing.
- An `rst_n` assertion mid-transfer aborts immediately. No `txn_done` is produced and the partial `data_rx` is discarded.

## Timing
- Reset values:
  - `spi_clk`=0 (it takes `cpol` on the first IDLE cycle after reset).
  - `spi_mosi`=0, `spi_cs_n`=all 1, `data_rx`=0, `txn_done`=0, `busy`=0.
- `busy` rises on the edge that accepts `txn_start`.
- `txn_done` is high exactly (2·DATA_W+2)·(`divider`+1) cycles after the accepting edge, and `busy` falls on that same edge.
- A new `txn_start` is accepted in the cycle `txn_done` is high. Back-to-back words therefore have no extra gap beyond SETUP/HOLD.
- `divider`=0 gives SCK = clk/2. `divider`=max needs no counter wrap beyond DIV_W bits.
- The MISO sample is taken from the pin value registered on the sampling edge, with no synchroniser.

## Test plan
- **Mode 0 loopback:** DATA_W=8, `divider`=0, mosi tied to miso, `data_tx`=0xA5 → `data_rx`=0xA5; `txn_done` 18 cycles after accept; SCK toggles 16 times and idles low.
- **All modes:** repeat the loopback with `divider`=3 for cpol/cpha = 00, 01, 10, 11. Each gives `data_rx`=0x3C from `data_tx`=0x3C, `txn_done` at 72 cycles, SCK idle equal to `cpol`, and the bench's slave model checks the sample edge.
- **LSB first:** `lsb_first`=1, `data_tx`=0x01 → the first MOSI bit is 1 and the remaining 7 bits are 0. A slave returning 0x80 MSB-first on the wire gives `data_rx`=0x01.
- **Chip select hold:** `cs_sel`=1, `keep_cs`=1, two words back-to-back → `spi_cs_n`=2'b01 continuously from the first SETUP to the second HOLD exit. A third word with `keep_cs`=0 deasserts CS after HOLD, and `cs_release` returns `spi_cs_n`=2'b11.
- **Start while busy:** `txn_start` pulsed during XFER with a different `data_tx` → ignored; `data_rx` reflects only the first word, and only one `txn_done` pulse occurs.
- **Reset mid-transfer:** assert `rst_n` low at the 5th SCK edge → outputs go immediately to reset values, with no `txn_done`. A subsequent transaction completes normally.
